// File: rtl/ex_fwd_ctrl_if.sv
// ID-to-EX forwarding control bundle: ID instruction tags and pipeline controls in,
// registered EX operand selects, EX tags and the load-use stall out.
interface ex_fwd_ctrl_if #(
  parameter int REG_BITS = 5
);
  logic                hold;
  logic                flush;
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_use_rs;
  logic                id_use_rt;
  logic                id_imm_b;
  logic [REG_BITS-1:0] id_rd;
  logic                id_wr_en;
  logic                id_is_load;
  logic                stall;
  logic                ex_valid;
  logic [2:0]          ex_sel_a;
  logic [2:0]          ex_sel_b;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_wr_en;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_imm_b, id_rd, id_wr_en, id_is_load,
    input  stall, ex_valid, ex_sel_a, ex_sel_b, ex_rd, ex_wr_en
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_imm_b, id_rd, id_wr_en, id_is_load,
    output stall, ex_valid, ex_sel_a, ex_sel_b, ex_rd, ex_wr_en
  );
endinterface

// File: rtl/ex_fwd_ctrl.sv
// EX-stage operand forwarding and load-use hazard controller; tracks destination
// tags of the EX, MEM, WB and WB+1 instructions and registers the operand selects.
module ex_fwd_ctrl #(
  parameter int REG_BITS = 5
) (
  input logic          clk,
  input logic          rst,
  ex_fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                wrEn;
    logic                isLoad;
  } tag_t;

  localparam logic [2:0] SelRf   = 3'b000;
  localparam logic [2:0] SelExMem = 3'b001;
  localparam logic [2:0] SelMemWb = 3'b010;
  localparam logic [2:0] SelWb1  = 3'b011;
  localparam logic [2:0] SelImm  = 3'b100;

  // Index 0 is EX, then MEM, WB and WB+1.
  tag_t       stage_q [4];
  logic [2:0] selA_q, selA_d;
  logic [2:0] selB_q, selB_d;
  logic       rsEx, rsMem, rsWb;
  logic       rtEx, rtMem, rtWb;
  logic       stall_d;

  function automatic logic srcMatch(input logic useSrc,
                                    input logic [REG_BITS-1:0] src,
                                    input tag_t t);
    return useSrc && (src != '0) && t.valid && t.wrEn && (t.rd == src);
  endfunction

  assign rsEx  = srcMatch(bus.id_use_rs, bus.id_rs, stage_q[0]);
  assign rsMem = srcMatch(bus.id_use_rs, bus.id_rs, stage_q[1]);
  assign rsWb  = srcMatch(bus.id_use_rs, bus.id_rs, stage_q[2]);
  assign rtEx  = srcMatch(bus.id_use_rt, bus.id_rt, stage_q[0]);
  assign rtMem = srcMatch(bus.id_use_rt, bus.id_rt, stage_q[1]);
  assign rtWb  = srcMatch(bus.id_use_rt, bus.id_rt, stage_q[2]);

  // Selects describe where the operand lives one cycle later, so the youngest producer wins.
  always_comb begin
    selA_d = SelRf;
    if (rsEx)       selA_d = SelExMem;
    else if (rsMem) selA_d = SelMemWb;
    else if (rsWb)  selA_d = SelWb1;

    selB_d = SelRf;
    if (bus.id_imm_b) selB_d = SelImm;
    else if (rtEx)    selB_d = SelExMem;
    else if (rtMem)   selB_d = SelMemWb;
    else if (rtWb)    selB_d = SelWb1;
  end

  assign stall_d = bus.id_valid && stage_q[0].isLoad && (rsEx || (!bus.id_imm_b && rtEx))
                   && !bus.hold && !bus.flush;

  assign bus.stall    = stall_d;
  assign bus.ex_valid = stage_q[0].valid;
  assign bus.ex_rd    = stage_q[0].rd;
  assign bus.ex_wr_en = stage_q[0].wrEn;
  assign bus.ex_sel_a = selA_q;
  assign bus.ex_sel_b = selB_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stage_q[i] <= '0;
      selA_q <= SelRf;
      selB_q <= SelRf;
    end else if (!bus.hold) begin
      for (int i = 1; i < 4; i++) stage_q[i] <= stage_q[i-1];
      if (bus.flush || stall_d || !bus.id_valid) begin
        stage_q[0] <= '0;
        selA_q     <= SelRf;
        selB_q     <= SelRf;
      end else begin
        stage_q[0] <= '{valid: 1'b1, rd: bus.id_rd, wrEn: bus.id_wr_en, isLoad: bus.id_is_load};
        selA_q     <= selA_d;
        selB_q     <= selB_d;
      end
    end
  end

endmodule

// File: doc/ex_fwd_ctrl.md
Name: ex_fwd_ctrl

Overview:
- Forwarding and hazard controller for the EX-stage operand muxes (A and B) of the 5-stage pipeline.
- Tracks destination tags of in-flight instructions (EX, MEM, WB, WB+1).
- Registers the 3-bit operand selects for the instruction entering EX.
- Raises a one-cycle load-use stall and honours global hold and branch flush.

Parameters:
- REG_BITS, 5, register-index width (32 architectural registers; register 0 is hard zero).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze (memory wait); no internal state changes.
- flush  in  1  branch taken; the ID instruction is squashed instead of entering EX.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_BITS  source A register index.
- id_rt  in  REG_BITS  source B register index.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_imm_b  in  1  operand B is the immediate.
- id_rd  in  REG_BITS  destination register index.
- id_wr_en  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- stall  out  1  combinational; ID/IF must hold and a bubble enters EX.
- ex_valid  out  1  EX holds a real instruction.
- ex_sel_a  out  3  operand-A mux select for the instruction in EX.
- ex_sel_b  out  3  operand-B mux select for the instruction in EX.
- ex_rd  out  REG_BITS  destination tag of the EX instruction.
- ex_wr_en  out  1  write-enable tag of the EX instruction.

Behaviour:
- Select encoding:
  - 000 register file
  - 001 EX/MEM result
  - 010 MEM/WB result
  - 011 WB+1 bypass (value written one cycle earlier)
  - 100 immediate (B only)
  - 101–111 never driven.
- Internal tag pipeline: four stages, EX → MEM → WB → WB1. Each stage holds {valid, rd, wr_en, is_load}. Tags advance one stage per cycle unless hold is asserted.
- Reset (async): all tag valids are 0. ex_sel_a = ex_sel_b = 000, ex_valid = 0, ex_rd = 0, ex_wr_en = 0, stall = 0.
- Match rule: source s matches stage X when all of the following hold:
  - use bit = 1
  - s ≠ 0
  - X.valid = 1
  - X.wr_en = 1
  - X.rd = s
- Select priority for the ID instruction (computed combinationally, registered into the EX outputs):
  - match EX → 001
  - else match MEM → 010
  - else match WB → 011
  - else 000
  - Youngest producer wins.
- Operand B: id_imm_b = 1 forces 100 regardless of rt matches.
- Load-use stall: stall = id_valid & EX.valid & EX.is_load & EX.wr_en & (rs matches EX.rd or, when !id_imm_b, rt matches EX.rd). Rs and rt use the match rule above.
  - Stall is gated to 0 while hold = 1 or flush = 1.
  - Stall lasts exactly one cycle. Next cycle the load is in MEM, the match yields 010, and no further stall occurs.
- Update each cycle, with priority rst > hold > flush > stall > normal:
  - hold = 1: every register keeps its value, including EX outputs. A flush asserted during hold is ignored; the requester holds flush until hold drops.
  - flush = 1: a bubble enters EX (valid 0, wr_en 0, selects 000). Older stages advance normally.
  - stall = 1: a bubble enters EX. Older stages advance.
  - normal: the ID instruction's tags and selects load into EX. If id_valid = 0 a bubble loads instead.
- Bubble tags: rd = 0, wr_en = 0, is_load = 0.
- ex_* outputs come directly from the EX-stage registers (latency 1 from ID).

Test Plan:
- Back-to-back ALU dependency: add r3 (wr), then sub using rs = r3 next cycle → ex_sel_a = 001 in the sub's EX cycle, stall = 0.
- Distance 2 and 3: producer r5, then unrelated, then consumer rt = r5 → ex_sel_b = 010. With two intervening instructions → 011. With three intervening → 000.
- Load-use: lw r7, then add rs = r7 → stall = 1 for exactly 1 cycle and a bubble appears (ex_valid = 0). Then the add reaches EX with ex_sel_a = 010.
- Priorities:
  - r4 written in EX and MEM simultaneously, consumer rs = r4 → 001.
  - rs = r0 with a producer writing r0 → 000.
  - id_imm_b = 1 with rt matching EX → ex_sel_b = 100 and no stall from rt.
- Hold and flush:
  - hold for 3 cycles mid-stream → all ex_* outputs unchanged, stall = 0.
  - flush coincident with a load-use pair → ex_valid = 0 next cycle, stall = 0.
  - flush during hold → ignored until hold drops.
- Async reset mid-stream: assert rst between clock edges → all outputs 000/0 immediately, with no clock edge required. After release, a prior producer no longer matches (sel 000).
